// File: rtl/dcache_wbuf_ctrl.sv
// D-cache write buffer and memory-side controller: DEPTH-entry line FIFO, read-miss priority, RAW hazard handling.
// Define WBUF_FORWARD_EN to serve read hits on buffered lines directly from the buffer.
module dcache_wbuf_ctrl #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned LINE_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              wb_push,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [LINE_W-1:0] wb_wdata,
    output logic              wb_full,
    output logic              wb_empty,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_done,
    output logic [LINE_W-1:0] rd_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        DONE
`ifdef WBUF_FORWARD_EN
        , FWD
`endif
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              push_ok;
    logic              pop;
    logic              hit;
    logic              skip_rd;
`ifdef WBUF_FORWARD_EN
    logic [PTR_W-1:0]  hit_idx;
`endif

    assign push_ok = wb_push && !wb_full;
    assign pop     = (state == WR) && mem_ready;

    always_comb begin
        count_next = count + CNT_W'(push_ok) - CNT_W'(pop);
    end

    // Walk oldest to newest so the last hit is the newest matching line.
    always_comb begin
        hit = 1'b0;
`ifdef WBUF_FORWARD_EN
        hit_idx = '0;
`endif
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count && addr_q[head + PTR_W'(i)] == rd_addr) begin
                hit = 1'b1;
`ifdef WBUF_FORWARD_EN
                hit_idx = head + PTR_W'(i);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_q[tail] <= wb_addr;
            data_q[tail] <= wb_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            wb_full   <= 1'b0;
            wb_empty  <= 1'b1;
            skip_rd   <= 1'b0;
            rd_done   <= 1'b0;
            rd_data   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop)     head <= head + 1'b1;
            count    <= count_next;
            wb_full  <= (count_next == CNT_W'(DEPTH));
            wb_empty <= (count_next == '0);
            skip_rd  <= (state == DONE);
            rd_done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (rd_req && !skip_rd && !hit) begin
                        state    <= RD;
                        mem_read <= 1'b1;
                        mem_addr <= rd_addr;
                    end
`ifdef WBUF_FORWARD_EN
                    else if (rd_req && !skip_rd) begin
                        state <= FWD;
                    end
`endif
                    // Without forwarding a hit implies a non-empty buffer, so hazards drain here.
                    else if (count != '0) begin
                        state     <= WR;
                        mem_write <= 1'b1;
                        mem_addr  <= addr_q[head];
                        mem_wdata <= data_q[head];
                    end
                end
                RD: begin
                    if (mem_ready) begin
                        state    <= DONE;
                        mem_read <= 1'b0;
                        rd_data  <= mem_rdata;
                        rd_done  <= 1'b1;
                    end
                end
                WR: begin
                    if (mem_ready) begin
                        state     <= IDLE;
                        mem_write <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
`ifdef WBUF_FORWARD_EN
                FWD: begin
                    state   <= DONE;
                    rd_data <= data_q[hit_idx];
                    rd_done <= 1'b1;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dcache_wbuf_ctrl.md
Name: dcache_wbuf_ctrl

Overview:
Parametrised write-buffer and memory-side controller that sits between the D-cache core and the line-wide memory port.
- Queues evicted dirty lines in a DEPTH-entry FIFO.
- Serves read misses ahead of queued writes.
- Resolves read-after-write hazards against buffered lines.
- Owns the single mem_read/mem_write port; the cache core only sees push/full and read-request/done.

Parameters:
DEPTH, 4, write-buffer entries; power of two, >=2
ADDR_W, 28, line address width
LINE_W, 128, line data width

Ports:
clk  in  1  clock
proc_reset  in  1  reset, synchronous, active-high
wb_push  in  1  enqueue evicted line this cycle
wb_addr  in  ADDR_W  line address of pushed line
wb_wdata  in  LINE_W  pushed line data
wb_full  out  1  buffer holds DEPTH entries
wb_empty  out  1  buffer holds 0 entries
rd_req  in  1  read-miss request, level, held until rd_done
rd_addr  in  ADDR_W  read-miss line address, stable while rd_req
rd_done  out  1  one-cycle pulse, rd_data valid
rd_data  out  LINE_W  returned line, held until next rd_done
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_addr  out  ADDR_W  memory line address
mem_wdata  out  LINE_W  memory write data
mem_rdata  in  LINE_W  memory read data, valid with mem_ready
mem_ready  in  1  memory accepts/completes current request

Behaviour:
Reset (proc_reset=1 at clk edge):
- All entries dropped; state IDLE.
- mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- rd_done=0, rd_data=0, wb_full=0, wb_empty=1.
- Reset mid-transaction aborts it; requests drop the next cycle.

FIFO:
- Circular; head/tail pointers wrap modulo DEPTH; count is 0..DEPTH.
- wb_full and wb_empty are registered from count.
- Push while wb_full=1 is ignored, even if a pop occurs in the same cycle.
- Push and pop in the same cycle when not full: count unchanged.

Match:
- Combinational compare of rd_addr against all valid entries.
- Excludes any entry being pushed in the same cycle.
- The newest matching entry wins.

FSM states: IDLE, RD, WR, DONE, FWD (FWD exists only with the macro).
IDLE:
- rd_req && !match -> RD.
- rd_req && match -> FWD (macro) / WR (no macro).
- !rd_req && !empty -> WR.
- Otherwise stay in IDLE.
- rd_req is ignored in the cycle after DONE.
RD:
- mem_read=1, mem_addr=rd_addr.
- On mem_ready: capture mem_rdata into rd_data -> DONE.
WR:
- mem_write=1, mem_addr/mem_wdata = head entry.
- On mem_ready: pop head -> IDLE, re-arbitrating after every line so a pending read cuts in.
DONE:
- rd_done=1 for exactly one cycle -> IDLE.
Requests and timing:
- mem_read and mem_write are never both 1.
- Requests and their address/data are held stable until mem_ready.
- Read latency: mem_ready in cycle N, rd_done in N+1.
- Pushes are accepted in every state.

Optional Feature:
Macro: WBUF_FORWARD_EN
- Defined: FWD state loads rd_data from the newest matching entry; rd_done the cycle after entering FWD (2 cycles from rd_req); no memory access; entry stays queued.
- Undefined: on match, the controller drains WR repeatedly, with no reads in between, until no entry matches. It then issues RD, so the read returns the just-written data.

Test Plan:
Reset, then idle -> wb_empty=1, wb_full=0, mem_read=mem_write=0, rd_done=0.
Fill and drain:
- Push 4 lines A0..A3 with mem_ready tied 0 -> wb_full=1; a 5th push is ignored.
- Release mem_ready -> mem_write in order A0..A3, each mem_wdata matching its push; wb_empty=1 afterwards.
Read priority:
- Buffer holds A0,A1; rd_req addr 0x0000100 (no match); mem_ready=1 with mem_rdata=0xDEADBEEF...
- -> mem_read issued before any mem_write; rd_done with rd_data=0xDEADBEEF...; writes resume next.
Hazard, macro on:
- Buffer holds addr 0x10 data D1, then 0x10 data D2; rd_req 0x10.
- -> rd_done 2 cycles later with rd_data=D2; mem_read never asserted.
Hazard, macro off: same stimulus -> both 0x10 writes complete before mem_read 0x10 asserts.
Reset mid-RD: assert proc_reset while mem_read=1 -> next cycle mem_read=0, wb_empty=1, no rd_done.
